// File: rtl/rep_timer_ctrl.sv
// Workout session controller: debounced rep counter plus a seconds countdown,
// sequenced through idle/run/pause/done, driving the display's Cn/Ti inputs.
module rep_timer_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 500000,
  parameter int TIME_LIMIT = 60,
  parameter int REP_GOAL   = 30
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Clear,
  input  logic       Rep,
  output logic [6:0] Cn,
  output logic [6:0] Ti,
  output logic       Running,
  output logic       Done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [6:0]    TL7       = 7'(TIME_LIMIT);
  localparam logic [6:0]    GOAL7     = 7'(REP_GOAL);
  localparam logic [6:0]    CN_MAX    = 7'd99;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  logic          sync1_q, sync2_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          deb_lvl_q, deb_lvl_d;
  logic          deb_prev_q;
  logic          rep_evt;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    cn_q, cn_d;
  logic [6:0]    ti_q, ti_d;
  logic          running_q, done_q;

  // The level flips on the edge the counter would reach DEB_CYCLES, so the
  // count never actually holds that value.
  always_comb begin
    deb_cnt_d = '0;
    deb_lvl_d = deb_lvl_q;
    if (sync2_q != deb_lvl_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_lvl_d = ~deb_lvl_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  assign rep_evt = deb_lvl_q & ~deb_prev_q;

  always_comb begin
    logic tick;
    tick    = 1'b0;
    state_d = state_q;
    presc_d = presc_q;
    cn_d    = cn_q;
    ti_d    = ti_q;
    if (Clear) begin
      state_d = S_IDLE;
      presc_d = '0;
      cn_d    = '0;
      ti_d    = TL7;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state_d = S_RUN;
            presc_d = '0;
            cn_d    = '0;
            ti_d    = TL7;
          end
        end
        S_PAUSE: begin
          if (Start) state_d = S_RUN;
        end
        S_RUN: begin
          // Start outranks Pause, and a Start while running changes nothing.
          if (Pause && !Start) begin
            state_d = S_PAUSE;
          end else begin
            tick    = (presc_q == PRESC_MAX);
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick && ti_q != 7'd0) ti_d = ti_q - 7'd1;
            if (rep_evt && cn_q != CN_MAX) cn_d = cn_q + 7'd1;
            if (ti_d == 7'd0 || cn_d == GOAL7) state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_cnt_q  <= '0;
      deb_lvl_q  <= 1'b0;
      deb_prev_q <= 1'b0;
      state_q    <= S_IDLE;
      presc_q    <= '0;
      cn_q       <= '0;
      ti_q       <= TL7;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sync1_q    <= Rep;
      sync2_q    <= sync1_q;
      deb_cnt_q  <= deb_cnt_d;
      deb_lvl_q  <= deb_lvl_d;
      deb_prev_q <= deb_lvl_q;
      state_q    <= state_d;
      presc_q    <= presc_d;
      cn_q       <= cn_d;
      ti_q       <= ti_d;
      running_q  <= (state_d == S_RUN);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign Cn      = cn_q;
  assign Ti      = ti_q;
  assign Running = running_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_rep_timer_ctrl.sv
// Bench for rep_timer_ctrl: vector table, hand-written corner sequences and a
// randomized run compared cycle by cycle against a behavioural model.
module tb_rep_timer_ctrl;

  localparam int TD   = 10;
  localparam int DEB  = 4;
  localparam int TL   = 5;
  localparam int GOAL = 3;

  logic       clk, rst_n, start, pause, clear, rep;
  logic [6:0] cn, ti;
  logic       running, done;

  int checks   = 0;
  int failures = 0;

  rep_timer_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DEB), .TIME_LIMIT(TL), .REP_GOAL(GOAL)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start(start), .Pause(pause), .Clear(clear), .Rep(rep),
    .Cn(cn), .Ti(ti), .Running(running), .Done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: session phase, elapsed run cycles, and the debounced
  // level derived from a window of synchronized sensor samples.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
  mst_t m_st;
  int   m_cn, m_ti, m_run_cyc, m_since_flip;
  bit   m_lvl, m_rose;
  bit   raw_q[$];
  bit   win[$];

  task automatic model_reset();
    m_st = M_IDLE; m_cn = 0; m_ti = TL; m_run_cyc = 0;
    m_lvl = 0; m_rose = 0; m_since_flip = 1000;
    raw_q = {1'b0, 1'b0};
    win = {};
  endtask

  task automatic model_edge(input bit s, input bit p, input bit c, input bit r);
    bit smp, ev, all_diff, flip;
    ev = m_rose;
    raw_q.push_back(r);
    smp = raw_q.pop_front();
    win.push_back(smp);
    if (win.size() > DEB) void'(win.pop_front());
    if (m_since_flip < 1000) m_since_flip++;
    all_diff = (win.size() == DEB);
    foreach (win[i]) if (win[i] == m_lvl) all_diff = 0;
    flip = all_diff && (m_since_flip >= DEB);
    m_rose = flip && !m_lvl;
    if (flip) begin
      m_lvl = !m_lvl;
      m_since_flip = 0;
    end
    if (c) begin
      m_st = M_IDLE; m_cn = 0; m_ti = TL; m_run_cyc = 0;
    end else begin
      case (m_st)
        M_IDLE, M_DONE: if (s) begin
          m_st = M_RUN; m_cn = 0; m_ti = TL; m_run_cyc = 0;
        end
        M_PAUSE: if (s) m_st = M_RUN;
        M_RUN: begin
          if (p && !s) m_st = M_PAUSE;
          else begin
            m_run_cyc++;
            if (m_run_cyc % TD == 0 && m_ti > 0) m_ti--;
            if (ev && m_cn < 99) m_cn++;
            if (m_ti == 0 || m_cn == GOAL) m_st = M_DONE;
          end
        end
        default: m_st = M_IDLE;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ecn, input int eti, input logic er, input logic ed);
    check({tag, ".Cn"}, 32'(cn), 32'(ecn));
    check({tag, ".Ti"}, 32'(ti), 32'(eti));
    check({tag, ".Running"}, 32'(running), 32'(er));
    check({tag, ".Done"}, 32'(done), 32'(ed));
  endtask

  task automatic step(input logic s, input logic p, input logic c, input logic r);
    start = s; pause = p; clear = c; rep = r;
    @(posedge clk);
    model_edge(s, p, c, r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; rep = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic s, p, c, r;
    int   n;
    int   cn, ti;
    logic run, dn;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic p, input logic c, input logic r,
                              input int n, input int ecn, input int eti,
                              input logic er, input logic ed);
    vec_t v;
    v.s = s; v.p = p; v.c = c; v.r = r; v.n = n;
    v.cn = ecn; v.ti = eti; v.run = er; v.dn = ed;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // s p c r  n   cn ti run done
    tbl.push_back(mk(0,0,0,0, 1,  0,5,0,0));  // idle
    tbl.push_back(mk(0,1,0,0, 1,  0,5,0,0));  // pause ignored in idle
    tbl.push_back(mk(1,0,0,0, 1,  0,5,1,0));  // start
    tbl.push_back(mk(0,0,0,0, 9,  0,5,1,0));  // prescaler at 9
    tbl.push_back(mk(0,0,0,0, 1,  0,4,1,0));  // first tick, 10 after start
    tbl.push_back(mk(0,0,0,0, 39, 0,1,1,0));  // 49 after start
    tbl.push_back(mk(0,0,0,0, 1,  0,0,0,1));  // timeout at 50
    tbl.push_back(mk(0,0,0,0, 5,  0,0,0,1));  // done holds
    tbl.push_back(mk(0,1,0,0, 1,  0,0,0,1));  // pause ignored in done
    tbl.push_back(mk(1,0,0,0, 1,  0,5,1,0));  // fresh restart
    tbl.push_back(mk(0,0,0,0, 3,  0,5,1,0));
    tbl.push_back(mk(1,1,1,0, 1,  0,5,0,0));  // clear wins over start/pause
    tbl.push_back(mk(1,0,0,0, 1,  0,5,1,0));
    tbl.push_back(mk(0,0,0,0, 6,  0,5,1,0));  // prescaler at 6
    tbl.push_back(mk(0,1,0,0, 1,  0,5,0,0));  // pause
    tbl.push_back(mk(0,0,0,0, 30, 0,5,0,0));
    tbl.push_back(mk(1,0,0,0, 1,  0,5,1,0));  // resume
    tbl.push_back(mk(0,0,0,0, 3,  0,5,1,0));
    tbl.push_back(mk(0,0,0,0, 1,  0,4,1,0));  // tick 4 edges after resume

    do_reset();
    check_all("reset", 0, TL, 1'b0, 1'b0);
    $display("reset: Cn=%0d Ti=%0d Running=%0b Done=%0b", cn, ti, running, done);

    foreach (tbl[i]) begin
      repeat (tbl[i].n) step(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].r);
      check_all($sformatf("vec%0d", i), tbl[i].cn, tbl[i].ti, tbl[i].run, tbl[i].dn);
      $display("vec %0d: s=%0b p=%0b c=%0b n=%0d -> Cn=%0d Ti=%0d Running=%0b Done=%0b",
               i, tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].n, cn, ti, running, done);
    end

    // Glitches shorter than the debounce window, then a held rep and its latency.
    do_reset();
    step(1, 0, 0, 0);
    begin
      logic [11:0] glitch;
      glitch = 12'b1101_0110_0000;
      for (int i = 11; i >= 0; i--) step(0, 0, 0, glitch[i]);
    end
    check("glitch.Cn", 32'(cn), 32'd0);
    for (int e = 1; e <= 20; e++) begin
      step(0, 0, 0, 1'b1);
      if (e == DEB + 2) check("latency.before", 32'(cn), 32'd0);
      if (e == DEB + 3) check("latency.at", 32'(cn), 32'd1);
    end
    repeat (10) step(0, 0, 0, 1'b0);
    check("held.Cn", 32'(cn), 32'd1);
    $display("seq glitch/latency: Cn=%0d Ti=%0d", cn, ti);

    // Three clean reps: DONE on the edge Cn reaches the goal, Ti frozen.
    do_reset();
    step(1, 0, 0, 0);
    for (int e = 1; e <= 36; e++) begin
      step(0, 0, 0, ((e - 1) % 12) < 6);
      if (e == 30) begin
        check("goal.pre.Cn", 32'(cn), 32'd2);
        check("goal.pre.Running", 32'(running), 32'd1);
      end
      if (e == 31) check_all("goal.hit", GOAL, 2, 1'b0, 1'b1);
      if (e == 36) check_all("goal.hold", GOAL, 2, 1'b0, 1'b1);
    end
    $display("seq goal: Cn=%0d Ti=%0d Done=%0b", cn, ti, done);

    // Reps during pause are discarded; prescaler resumes from its held value.
    do_reset();
    step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int e = 1; e <= 30; e++) step(0, 0, 0, e <= 10);
    check_all("pause.hold", 0, TL, 1'b0, 1'b0);
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    check("resume.pre.Ti", 32'(ti), 32'(TL));
    step(0, 0, 0, 0);
    check_all("resume.tick", 0, TL - 1, 1'b1, 1'b0);
    $display("seq pause: Cn=%0d Ti=%0d Running=%0b", cn, ti, running);

    // Asynchronous reset mid-run, observed before any clock edge.
    do_reset();
    step(1, 0, 0, 0);
    for (int e = 1; e <= 12; e++) step(0, 0, 0, e <= 8);
    check_all("async.pre", 1, TL - 1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all("async.rst", 0, TL, 1'b0, 1'b0);
    $display("seq async reset: Cn=%0d Ti=%0d Running=%0b Done=%0b", cn, ti, running, done);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized commands and bouncy rep levels against the model.
    do_reset();
    begin
      logic r_lvl;
      int   r_left;
      logic s, p, c;
      r_lvl = 1'b0;
      r_left = 0;
      for (int cyc = 0; cyc < 2500; cyc++) begin
        if (r_left == 0) begin
          r_lvl = ~r_lvl;
          r_left = $urandom_range(1, 12);
        end
        r_left--;
        s = ($urandom_range(0, 19) == 0);
        p = ($urandom_range(0, 24) == 0);
        c = ($urandom_range(0, 149) == 0);
        step(s, p, c, r_lvl);
        check_all("rand", m_cn, m_ti, m_st == M_RUN, m_st == M_DONE);
        if (s || p || c)
          $display("rand cyc %0d: s=%0b p=%0b c=%0b -> Cn=%0d Ti=%0d Running=%0b Done=%0b",
                   cyc, s, p, c, cn, ti, running, done);
        if (failures > 40) break;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
